// File: rtl/pipeline_if_stage.sv
// Instruction fetch stage: credit-limited requests to instruction memory, in-order
// response buffering, and a registered hand-off to decode with redirect flush.
module pipeline_if_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_IF,
  output logic [63:0] pc_IF,
  output logic        valid_IF
);

  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PW = $clog2(BUF_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(BUF_DEPTH);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } entry_t;

  logic [63:0]   fetch_pc;
  logic [63:0]   resp_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  entry_t        fifo_mem [BUF_DEPTH];
  entry_t        resp_entry;
  entry_t        head;

  logic [CW:0] credit_used;
  logic        fire;
  logic        kept;
  logic        dropped;
  logic        fifo_empty;
  logic        load;
  logic        pop;
  logic        bypass;
  logic        push;

  always_comb begin
    credit_used = {1'b0, inflight} + {1'b0, fifo_count};
    imem_req    = !reset && !redirect && (credit_used < DEPTH_W);
    fire        = imem_req && imem_gnt;
    dropped     = imem_rvalid && (drop_cnt != '0);
    // A response arriving with a redirect belongs to the old stream and is never kept.
    kept        = imem_rvalid && (drop_cnt == '0) && !redirect;
    fifo_empty  = (fifo_count == '0);
    load        = !stall && !redirect;
    pop         = load && !fifo_empty;
    bypass      = load && fifo_empty && kept;
    push        = kept && !bypass;
    resp_entry  = {resp_pc, imem_rdata};
    head        = fifo_mem[rd_ptr];
  end

  assign imem_addr = fetch_pc;

  // NOTE: all state registers use non-blocking assignments so every block sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight + CW'(fire) - CW'(imem_rvalid);
      if (redirect) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        // Every request still outstanding after this cycle belongs to a dead stream.
        drop_cnt <= inflight - CW'(imem_rvalid);
      end else begin
        if (fire)    fetch_pc <= fetch_pc + 64'd4;
        if (kept)    resp_pc  <= resp_pc + 64'd4;
        if (dropped) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else if (redirect) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  // NOTE: storage is not reset; the count and pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= resp_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instruction_IF <= NOP;
      pc_IF          <= '0;
      valid_IF       <= 1'b0;
    end else if (redirect) begin
      instruction_IF <= NOP;
      pc_IF          <= '0;
      valid_IF       <= 1'b0;
    end else if (!stall) begin
      if (pop) begin
        instruction_IF <= head.inst;
        pc_IF          <= head.pc;
        valid_IF       <= 1'b1;
      end else if (bypass) begin
        instruction_IF <= imem_rdata;
        pc_IF          <= resp_pc;
        valid_IF       <= 1'b1;
      end else begin
        instruction_IF <= NOP;
        pc_IF          <= '0;
        valid_IF       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_if_stage.sv
// Self-checking bench for pipeline_if_stage: behavioural memory, stream scoreboard,
// directed timing scenarios and a randomized stall/redirect/grant phase.
module tb_pipeline_if_stage;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instruction_IF;
  logic [63:0] pc_IF;
  logic        valid_IF;

  pipeline_if_stage #(.RESET_PC(RESET_PC), .BUF_DEPTH(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .instruction_IF(instruction_IF),
    .pc_IF         (pc_IF),
    .valid_IF      (valid_IF)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  int cyc     = 0;
  int gnt_pct = 100;
  int lat_min = 1;
  int lat_max = 1;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } pend_t;

  pend_t       pend_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] model_fetch = RESET_PC;

  logic        hold_prev  = 1'b0;
  logic        redir_prev = 1'b0;
  logic [63:0] pc_prev;
  logic [31:0] inst_prev;
  logic        valid_prev;
  logic [63:0] mon_exp;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h6b3d_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Behavioural memory plus request-side model: every granted fetch of the live stream
  // must follow the expected address sequence and is queued as an expected output.
  initial begin : memory
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (!reset && imem_req && imem_gnt)
        pend_q.push_back('{addr: imem_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
      if (reset) begin
        exp_q.delete();
        model_fetch = RESET_PC;
      end else if (redirect) begin
        check("no_req_in_redirect", imem_req, 0);
        exp_q.delete();
        model_fetch = redirect_pc;
      end else if (imem_req && imem_gnt) begin
        check("fetch_addr", imem_addr, model_fetch);
        exp_q.push_back(model_fetch);
        model_fetch += 64'd4;
      end
      @(posedge clk);
      #1;
      cyc++;
      imem_gnt    = (int'($urandom_range(99, 0)) < gnt_pct);
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (reset) begin
        pend_q.delete();
      end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = inst_of(pend_q[0].addr);
        void'(pend_q.pop_front());
      end
    end
  end

  // Output monitor: bubbles, stall hold, redirect flush, and in-order stream delivery.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_prev  = 1'b0;
        redir_prev = 1'b0;
      end else begin
        if (!valid_IF) begin
          check("bubble_inst", instruction_IF, NOP);
          check("bubble_pc", pc_IF, 64'h0);
        end
        if (redir_prev) check("redirect_bubble", valid_IF, 0);
        if (hold_prev) begin
          check("stall_hold_pc", pc_IF, pc_prev);
          check("stall_hold_inst", instruction_IF, inst_prev);
          check("stall_hold_valid", valid_IF, valid_prev);
        end
        if (valid_IF && !stall && !redirect) begin
          n_out++;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: got pc 0x%0h, want no instruction", pc_IF);
          end else begin
            mon_exp = exp_q.pop_front();
            check("out_pc", pc_IF, mon_exp);
            check("out_inst", instruction_IF, inst_of(mon_exp));
          end
        end
        hold_prev  = stall && !redirect;
        redir_prev = redirect;
        pc_prev    = pc_IF;
        inst_prev  = instruction_IF;
        valid_prev = valid_IF;
      end
    end
  end

  task automatic wait_two_outstanding();
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      next_cycle();
      @(negedge clk);
      found = !imem_req && !imem_rvalid;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL outstanding_wait: got no full-credit cycle, want one within 40 cycles");
    end
  endtask

  initial begin : stimulus
    int first;
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_valid", valid_IF, 0);
    check("rst_inst", instruction_IF, NOP);
    check("rst_pc", pc_IF, 64'h0);

    // Streaming from reset, then a 4-cycle stall while 0x10 is on the output.
    next_cycle();
    reset = 1'b0;
    #1;
    check("release_req", imem_req, 1);
    check("release_addr", imem_addr, RESET_PC);
    for (int c = 1; c <= 13; c++) begin
      next_cycle();
      stall = (c >= 6 && c <= 9);
      @(negedge clk);
      if (c == 1) check("first_valid_latency", valid_IF, 0);
      if (c >= 2 && c <= 5) begin
        check("stream_valid", valid_IF, 1);
        check("stream_pc", pc_IF, 64'(4 * (c - 2)));
      end
      if (c >= 6 && c <= 9) begin
        check("stall_pc", pc_IF, 64'h10);
        check("stall_valid", valid_IF, 1);
      end
      if (c >= 7 && c <= 9) check("stall_credit_req", imem_req, 0);
      if (c >= 11 && c <= 13) begin
        check("release_valid", valid_IF, 1);
        check("release_pc", pc_IF, 64'h14 + 64'(4 * (c - 11)));
      end
    end

    // Redirect with two requests outstanding at 3-cycle memory latency.
    lat_min = 3;
    lat_max = 3;
    wait_two_outstanding();
    next_cycle();
    redirect    = 1'b1;
    redirect_pc = 64'h1000;
    next_cycle();
    redirect = 1'b0;
    @(negedge clk);
    check("redir_req", imem_req, 1);
    check("redir_addr", imem_addr, 64'h1000);
    check("redir_bubble1", valid_IF, 0);
    for (int k = 2; k <= 6; k++) begin
      next_cycle();
      @(negedge clk);
      if (k <= 4) check("redir_bubble", valid_IF, 0);
      if (k >= 5) begin
        check("redir_valid", valid_IF, 1);
        check("redir_pc", pc_IF, 64'h1000 + 64'(4 * (k - 5)));
      end
    end

    // Redirect together with stall and a same-cycle response.
    wait_two_outstanding();
    next_cycle();
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 64'h2000;
    next_cycle();
    stall    = 1'b0;
    redirect = 1'b0;
    @(negedge clk);
    check("rs_bubble", valid_IF, 0);
    check("rs_req", imem_req, 1);
    check("rs_addr", imem_addr, 64'h2000);
    for (int k = 2; k <= 5; k++) begin
      next_cycle();
      @(negedge clk);
      if (k <= 4) check("rs_wait_bubble", valid_IF, 0);
      if (k == 5) begin
        check("rs_valid", valid_IF, 1);
        check("rs_pc", pc_IF, 64'h2000);
      end
    end

    // Back-to-back redirects: 0x100 must never surface.
    lat_min = 1;
    lat_max = 1;
    repeat (5) next_cycle();
    redirect    = 1'b1;
    redirect_pc = 64'h100;
    next_cycle();
    redirect_pc = 64'h200;
    @(negedge clk);
    check("b2b_no_req", imem_req, 0);
    next_cycle();
    redirect = 1'b0;
    @(negedge clk);
    check("b2b_addr", imem_addr, 64'h200);
    first = -1;
    for (int k = 3; k <= 10; k++) begin
      next_cycle();
      @(negedge clk);
      if (valid_IF && first < 0) begin
        first = k;
        check("b2b_first_pc", pc_IF, 64'h200);
      end
    end
    check("b2b_first_cycle", 64'(first), 64'd4);

    // Mid-operation reset with a full buffer.
    next_cycle();
    stall = 1'b1;
    repeat (4) next_cycle();
    @(negedge clk);
    check("full_credit_req", imem_req, 0);
    next_cycle();
    reset = 1'b1;
    #1;
    check("mid_rst_valid", valid_IF, 0);
    check("mid_rst_inst", instruction_IF, NOP);
    check("mid_rst_pc", pc_IF, 64'h0);
    check("mid_rst_req", imem_req, 0);
    check("mid_rst_addr", imem_addr, RESET_PC);
    next_cycle();
    stall = 1'b0;
    next_cycle();
    reset = 1'b0;
    #1;
    check("restart_addr", imem_addr, RESET_PC);
    for (int k = 1; k <= 2; k++) begin
      next_cycle();
      @(negedge clk);
      if (k == 1) check("restart_bubble", valid_IF, 0);
      if (k == 2) begin
        check("restart_valid", valid_IF, 1);
        check("restart_pc", pc_IF, RESET_PC);
      end
    end

    // Randomized grants, latencies, stalls and redirects (including 64-bit wrap).
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      if (i % 500 == 0) begin
        gnt_pct = int'($urandom_range(100, 40));
        lat_max = int'($urandom_range(4, 1));
      end
      stall    = (int'($urandom_range(99, 0)) < 25);
      redirect = (int'($urandom_range(99, 0)) < 4);
      if ($urandom_range(3, 0) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
      else redirect_pc = {$urandom, $urandom} & ~64'h3;
    end
    stall    = 1'b0;
    redirect = 1'b0;
    repeat (30) next_cycle();
    check("random_progress", 64'(n_out > 300), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish before 2000000 time units");
    $fatal(1);
  end

endmodule
